// File: rtl/dmux_router_pkg.sv
// Shared types and constants for the dmux frame router.
// Optional feature macro: DMUX_ROUTER_PARITY_EN (adds the PARITY state and parity_err).
package dmux_router_pkg;

  localparam int ADDR_W = 2;
  localparam int NUM_CH = 4;
  // Bit counter width; PAYLOAD_LEN is limited to 1..255.
  localparam int BCNT_W = 8;

  // PARITY is always present in the encoding so debug decoders see one
  // stable state map; it is unreachable unless parity is enabled.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // True when the bit count points at the final payload bit of a frame.
  function automatic logic is_last_bit(input logic [BCNT_W-1:0] cnt,
                                       input int               len);
    return cnt == BCNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/dmux_router_cnt.sv
// Per-channel delivered-frame counter: wraps from all-ones back to zero.
module dmux_router_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled events; natural overflow provides the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmux_frame_router.sv
// Serial frame parser feeding the 1-to-4 demux select/data pair.
// Frame: start bit (1), 2 address bits MSB first, PAYLOAD_LEN payload bits,
// then a single DONE cycle. Define DMUX_ROUTER_PARITY_EN to append an
// even-parity bit after the payload and expose parity_err.
//
// Handshake: a bit moves on a rising clk edge where in_valid && in_ready.
// in_ready never depends on in_valid; in PAYLOAD it follows out_ready
// combinationally, so a stalled consumer stalls the serial input and no
// bit is lost. i_valid is a one-cycle registered strobe, one per
// forwarded payload bit.
module dmux_frame_router
  import dmux_router_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       s,
  output logic                    i,
  output logic                    i_valid,
  output logic                    busy,
  output logic                    frame_done,
  output logic [NUM_CH*CNT_W-1:0] frame_cnt,
`ifdef DMUX_ROUTER_PARITY_EN
  output logic                    parity_err,
`endif
  output state_t                  o_dbg_state
);

  state_t              r_state;
  state_t              w_next;
  logic                w_xfer;
  logic                w_last;
  logic                w_done;
  logic                r_addr_phase;
  logic                r_addr_msb;
  logic [ADDR_W-1:0]   r_s;
  logic [BCNT_W-1:0]   r_bcnt;
  logic                r_i;
  logic                r_i_valid;
`ifdef DMUX_ROUTER_PARITY_EN
  logic                r_par;
  logic                r_parity_err;
  logic                w_par_bad;
`endif

  assign w_xfer = in_valid && in_ready;
  assign w_last = is_last_bit(r_bcnt, PAYLOAD_LEN);
  assign w_done = (r_state == DONE);
`ifdef DMUX_ROUTER_PARITY_EN
  // Even parity: payload ones plus the parity bit must be even.
  assign w_par_bad = r_par ^ in_bit;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and input-side ready.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_xfer && in_bit) w_next = ADDR;
      end
      ADDR: begin
        in_ready = 1'b1;
        if (w_xfer && r_addr_phase) w_next = PAYLOAD;
      end
      PAYLOAD: begin
        in_ready = out_ready;
        if (w_xfer && w_last) begin
`ifdef DMUX_ROUTER_PARITY_EN
          w_next = PARITY;
`else
          w_next = DONE;
`endif
        end
      end
      PARITY: begin
`ifdef DMUX_ROUTER_PARITY_EN
        in_ready = 1'b1;
        if (w_xfer) w_next = w_par_bad ? IDLE : DONE;
`else
        w_next = IDLE;
`endif
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: address capture, payload forwarding, bit count, parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_phase <= 1'b0;
      r_addr_msb   <= 1'b0;
      r_s          <= '0;
      r_bcnt       <= '0;
      r_i          <= 1'b0;
      r_i_valid    <= 1'b0;
`ifdef DMUX_ROUTER_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_i          <= 1'b0;
      r_i_valid    <= 1'b0;
`ifdef DMUX_ROUTER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ADDR: begin
          if (w_xfer) begin
            if (!r_addr_phase) begin
              r_addr_msb   <= in_bit;
              r_addr_phase <= 1'b1;
            end else begin
              // Select only changes once the full address is known.
              r_s          <= {r_addr_msb, in_bit};
              r_addr_phase <= 1'b0;
              r_bcnt       <= '0;
`ifdef DMUX_ROUTER_PARITY_EN
              r_par        <= 1'b0;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_i       <= in_bit;
            r_i_valid <= 1'b1;
            r_bcnt    <= r_bcnt + BCNT_W'(1);
`ifdef DMUX_ROUTER_PARITY_EN
            r_par     <= r_par ^ in_bit;
`endif
          end
        end
`ifdef DMUX_ROUTER_PARITY_EN
        PARITY: begin
          if (w_xfer) r_parity_err <= w_par_bad;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // One wrapping counter per channel, bumped on DONE for the held select.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
    dmux_router_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_done && (r_s == ADDR_W'(ch))),
      .o_cnt (frame_cnt[ch*CNT_W +: CNT_W])
    );
  end

  assign s           = r_s;
  assign i           = r_i;
  assign i_valid     = r_i_valid;
  assign busy        = (r_state != IDLE);
  assign frame_done  = w_done;
  assign o_dbg_state = r_state;
`ifdef DMUX_ROUTER_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_dmux_frame_router.sv
// Self-checking bench for dmux_frame_router (default parameters).
// Build with DMUX_ROUTER_PARITY_EN defined to also cover the parity frame end.
module tb_dmux_frame_router;
  import dmux_router_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        out_ready;
  logic [1:0]  s;
  logic        i;
  logic        i_valid;
  logic        busy;
  logic        frame_done;
  logic [31:0] frame_cnt;
  state_t      dbg_state;
`ifdef DMUX_ROUTER_PARITY_EN
  logic        parity_err;
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmux_frame_router #(
    .PAYLOAD_LEN(8),
    .CNT_W(8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .s          (s),
    .i          (i),
    .i_valid    (i_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
`ifdef DMUX_ROUTER_PARITY_EN
    .parity_err (parity_err),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];        // {channel, payload bit} in delivery order
  logic [1:0] exp_frame_q[$];  // channel of each frame expected to complete
  logic [7:0] model_cnt[4];
  int         stall_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_vec();
    return {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]};
  endfunction

  // Output monitor: pops expected payload bits and completed frames.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_valid) begin
        if (exp_q.size() == 0) check("spurious_i_valid", 32'd1, 32'd0);
        else check("payload_s_i", {29'd0, s, i}, {29'd0, exp_q.pop_front()});
      end else begin
        check("i_zero_when_idle", {31'd0, i}, 32'd0);
      end
      if (frame_done) begin
        if (exp_frame_q.size() == 0) check("spurious_frame_done", 32'd1, 32'd0);
        else begin
          logic [1:0] ch;
          ch = exp_frame_q.pop_front();
          check("done_channel", {30'd0, s}, {30'd0, ch});
          model_cnt[ch] = model_cnt[ch] + 8'd1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one bit until it is accepted; out_ready follows stall_left.
  task automatic send_bit(input logic b);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 64) begin
      @(negedge clk);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = 1'b1;
      in_bit   = b;
      #1;
      if (!out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      acc = in_ready;
      @(posedge clk);
      tries++;
    end
    #1;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [7:0] pay,
                            input int stall_after, input bit bad_par);
    int c0;
    int stalls;
    stalls = 0;
    send_bit(1'b1);
    c0 = cyc;
    send_bit(ch[1]);
    send_bit(ch[0]);
    check("addr_s", {30'd0, s}, {30'd0, ch});
    if (!bad_par) exp_frame_q.push_back(ch);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({ch, pay[7-k]});
      send_bit(pay[7-k]);
      if (k + 1 == stall_after) begin
        stall_left = 3;
        stalls = 3;
      end
    end
`ifdef DMUX_ROUTER_PARITY_EN
    send_bit((^pay) ^ bad_par);
`endif
    @(negedge clk);
    if (bad_par) begin
      in_valid = 1'b0;
`ifdef DMUX_ROUTER_PARITY_EN
      #1;
      check("parity_err_pulse", {31'd0, parity_err}, 32'd1);
      check("no_done_on_bad_par", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      #1;
      check("parity_err_clear", {31'd0, parity_err}, 32'd0);
`endif
    end else begin
      // Offer a start bit during DONE: it must not be taken.
      in_valid = 1'b1;
      in_bit   = 1'b1;
      #1;
      check("frame_done", {31'd0, frame_done}, 32'd1);
      check("done_in_ready", {31'd0, in_ready}, 32'd0);
      check("frame_cycles", cyc - c0 + 2, 12 + stalls + PAR_EXTRA);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("idle_after_done", {31'd0, busy}, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) model_cnt[c] = 8'd0;
    #23;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_s", {30'd0, s}, 32'd0);
    check("rst_i", {31'd0, i}, 32'd0);
    check("rst_i_valid", {31'd0, i_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Idle line: zeros are discarded.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b0;
      #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_i_valid", {31'd0, i_valid}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("idle_busy_end", {31'd0, busy}, 32'd0);
    check("idle_frame_cnt", frame_cnt, 32'd0);

    // Channel 2 frame, no stall, then the same frame with a 3-cycle stall.
    send_frame(2'b10, 8'b1011_0011, 0, 1'b0);
    check("cnt_after_f1", frame_cnt, model_vec());
    check("cnt2_is_1", {24'd0, frame_cnt[23:16]}, 32'd1);
    send_frame(2'b10, 8'b1011_0011, 4, 1'b0);
    check("cnt_after_stall", frame_cnt, model_vec());

    // Randomised frames to random channels with random stall points.
    for (int f = 0; f < 10; f++) begin
      send_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 7), 1'b0);
    end
    check("cnt_after_random", frame_cnt, model_vec());

    // 256 frames to channel 3: its counter wraps to the value it started at.
    begin
      logic [7:0] c3_before;
      c3_before = model_cnt[3];
      for (int f = 0; f < 256; f++) send_frame(2'b11, 8'($urandom_range(0, 255)), 0, 1'b0);
      check("cnt3_wrapped", {24'd0, frame_cnt[31:24]}, {24'd0, c3_before});
      check("cnt_after_wrap", frame_cnt, model_vec());
    end

    // Reset mid-frame after payload bit 5.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({2'b01, 1'b1});
      send_bit(1'b1);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int c = 0; c < 4; c++) model_cnt[c] = 8'd0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_i_valid", {31'd0, i_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_s", {30'd0, s}, 32'd0);
    check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("mid_rst_frame_cnt", frame_cnt, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(2'b00, 8'b0110_1001, 0, 1'b0);
    check("cnt0_after_rst", frame_cnt, 32'd1);

`ifdef DMUX_ROUTER_PARITY_EN
    // Odd number of ones with parity bit 0: error, no count.
    send_frame(2'b01, 8'b1011_0011, 0, 1'b1);
    check("cnt_after_bad_par", frame_cnt, model_vec());
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size() + exp_frame_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed busy=%0b expected run to finish", busy);
    $fatal(1);
  end

endmodule
